// File: rtl/mem_stage_defs_pkg.sv
// rtl/mem_stage_defs_pkg.sv - shared size/state encodings for the memory-access stage
package mem_stage_defs_pkg;

    localparam int DEFAULT_MEM_WORDS = 256;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_MERGE   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte/half lane merge for stores and lane extract for loads
// Ports:
//   mem_word    in  32  word read from memory
//   wdata       in  32  right-aligned store data
//   size        in  2   access size (byte/half/word)
//   offset      in  2   byte offset within the word (addr[1:0])
//   is_signed   in  1   sign-extend loaded lane
//   merged_word out 32  mem_word with the addressed lane replaced by wdata
//   load_data   out 32  addressed lane of mem_word, extended to 32 bits
module lsu_lane_align
    import mem_stage_defs_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_signed,
    output logic [31:0] merged_word,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        merged_word = mem_word;
        case (size)
            SZ_BYTE: merged_word[{offset, 3'b000} +: 8]        = wdata[7:0];
            SZ_HALF: merged_word[{offset[1], 4'b0000} +: 16]   = wdata[15:0];
            default: merged_word = wdata;
        endcase
    end

    always_comb begin
        byte_lane = mem_word[{offset, 3'b000} +: 8];
        half_lane = mem_word[{offset[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: load_data = {{24{is_signed & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_data = {{16{is_signed & half_lane[15]}}, half_lane};
            default: load_data = mem_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store stage with RMW sub-word stores
// Ports:
//   clk, reset                       clock, async active-high reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_write/size/signed/addr/wdata request fields, held by producer until accepted
//   resp_valid/resp_ready            response handshake
//   resp_rdata/resp_error            load result / error flag, stable while resp_valid
//   mem_write_enable/address/write_data  synchronous memory write port + word address
//   mem_read_data                    registered memory read data (one cycle after address)
module load_store_unit
    import mem_stage_defs_pkg::*;
#(
    parameter int MEM_WORDS = DEFAULT_MEM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

    lsu_state_e  state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;

    logic        req_error;
    logic [31:0] merged_word;
    logic [31:0] load_data;

    lsu_lane_align u_lane_align (
        .mem_word    (mem_read_data),
        .wdata       (wdata_q),
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .is_signed   (signed_q),
        .merged_word (merged_word),
        .load_data   (load_data)
    );

    // Checked on the live request so an error goes straight to RESP without touching memory.
    always_comb begin
        req_error = (req_size == SZ_RSVD)
                 || (req_size == SZ_HALF && req_addr[0])
                 || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                 || ({1'b0, req_addr} >= ADDR_LIMIT);
    end

    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        size_d           = size_q;
        signed_d         = signed_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        resp_rdata_d     = resp_rdata_q;
        resp_error_d     = resp_error_q;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        mem_write_enable = 1'b0;
        mem_write_data   = 32'd0;
        mem_address      = {2'b00, addr_q[31:2]};

        case (state_q)
            ST_IDLE: begin
                req_ready   = 1'b1;
                mem_address = 32'd0;
                if (req_valid) begin
                    write_d      = req_write;
                    size_d       = req_size;
                    signed_d     = req_signed;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    resp_rdata_d = 32'd0;
                    resp_error_d = req_error;
                    state_d      = req_error ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (write_q && size_q == SZ_WORD) begin
                    mem_write_enable = 1'b1;
                    mem_write_data   = wdata_q;
                    state_d          = ST_RESP;
                end else if (write_q) begin
                    state_d = ST_MERGE;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_MERGE: begin
                // Old word arrives this cycle; the merged word is written on the exit edge.
                mem_write_enable = 1'b1;
                mem_write_data   = merged_word;
                state_d          = ST_RESP;
            end
            ST_CAPTURE: begin
                resp_rdata_d = load_data;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            resp_rdata_q <= 32'd0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with byte-level reference memory
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = 32'd0;

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_signed       (req_signed),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    // Attached synchronous memory.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address[7:0]] <= mem_write_data;
        mem_read_data <= mem[mem_address[7:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: flat little-endian byte array.
    logic [7:0] ref_bytes [1024];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          writes;
        int          acc_cyc;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t model(input logic w, input logic [1:0] sz, input logic sg,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int n;
        int base;
        logic [31:0] v;
        e.err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || (a >= 32'd1024);
        e.rdata = 32'd0;
        e.writes = 0;
        e.acc_cyc = 0;
        if (e.err) begin
            e.lat = 1;
        end else begin
            n = 1 << sz;
            base = int'(a[9:0]);
            if (w) begin
                for (int i = 0; i < n; i++) ref_bytes[base + i] = wd[8*i +: 8];
                e.writes = 1;
                e.lat = (n == 4) ? 2 : 3;
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[base + i];
                if (sg && v[8*n-1])
                    for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                e.rdata = v;
                e.lat = 3;
            end
        end
        return e;
    endfunction

    // Response-ready driver: 0 random, 1 held low, 2 held high.
    int rr_mode = 2;
    initial forever begin
        @(posedge clk);
        #2;
        resp_ready = (rr_mode == 1) ? 1'b0 : (rr_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard on every response handshake.
    bit          mon_en = 1'b1;
    bit          seen = 1'b0;
    int          we_cnt = 0;
    int          last_hs_cyc = 0;
    logic [31:0] held_rdata;
    logic        held_err;

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (mem_write_enable) we_cnt++;
            if (resp_valid) begin
                check("req_ready_while_resp", {31'd0, req_ready}, 32'd0);
                if (!seen) begin
                    seen = 1'b1;
                    held_rdata = resp_rdata;
                    held_err = resp_error;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_resp actual=resp_valid required=no_response");
                    end else begin
                        check("latency", cyc - exp_q[0].acc_cyc + 1, exp_q[0].lat);
                    end
                end else begin
                    check("hold_rdata", resp_rdata, held_rdata);
                    check("hold_error", {31'd0, resp_error}, {31'd0, held_err});
                end
                if (resp_ready) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("rdata", resp_rdata, e.rdata);
                        check("error", {31'd0, resp_error}, {31'd0, e.err});
                        check("write_pulses", we_cnt, e.writes);
                    end
                    seen = 1'b0;
                    we_cnt = 0;
                    last_hs_cyc = cyc;
                end
            end
        end
    end

    int last_acc_cyc = 0;

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int guard = 0;
        req_write = w;
        req_size = sz;
        req_signed = sg;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=not_accepted required=accepted addr=0x%08h", a);
                req_valid = 1'b0;
                return;
            end
        end
        e = model(w, sz, sg, a, wd);
        e.acc_cyc = cyc + 1;
        last_acc_cyc = e.acc_cyc;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        int g = 0;
        req_valid = 1'b0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [31:0] old_word;
        logic [31:0] ra;
        logic [1:0]  rs;
        int g;

        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = mem[i][8*b +: 8];
        end

        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_error", {31'd0, resp_error}, 32'd0);
        check("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed sequence.
        do_req(1'b1, 2'd2, 1'b0, 32'h14, 32'hDEADBEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 32'h15, 32'h123456AA);
        drain();
        check("word5_after_byte_store", mem[5], 32'hDEADAAEF);
        do_req(1'b0, 2'd0, 1'b1, 32'h15, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h15, 32'h0);
        do_req(1'b0, 2'd1, 1'b1, 32'h16, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 32'h16, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h14, 32'hFFFF1234);
        drain();
        check("word5_after_half_store", mem[5], 32'hDEAD1234);
        do_req(1'b0, 2'd1, 1'b0, 32'h15, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h402, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D);
        do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h55555555);
        drain();

        // Backpressure with a queued request behind the response.
        rr_mode = 1;
        do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
        req_write = 1'b0;
        req_size = 2'd0;
        req_signed = 1'b1;
        req_addr = 32'h17;
        g = 0;
        while (!resp_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("bp_resp_valid_seen", {31'd0, resp_valid}, 32'd1);
        repeat (5) @(negedge clk);
        check("bp_resp_valid_held", {31'd0, resp_valid}, 32'd1);
        check("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
        rr_mode = 2;
        do_req(1'b0, 2'd0, 1'b1, 32'h17, 32'h0);
        check("queued_accept_cycle", last_acc_cyc, last_hs_cyc + 2);
        drain();

        // Randomized traffic.
        rr_mode = 0;
        repeat (300) begin
            case ($urandom_range(0, 7))
                0:       ra = $urandom;
                1:       ra = $urandom_range(1016, 1100);
                default: ra = $urandom_range(0, 127);
            endcase
            rs = 2'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom);
        end
        drain();
        rr_mode = 2;

        for (int i = 0; i < 32; i++)
            check("mem_final", mem[i], {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]});

        // Reset during MERGE of a half store.
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        mon_en = 1'b0;
        req_write = 1'b1;
        req_size = 2'd1;
        req_signed = 1'b0;
        req_addr = 32'h14;
        req_wdata = 32'h00005678;
        req_valid = 1'b1;
        old_word = mem[5];
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("merge_we_before_reset", {31'd0, mem_write_enable}, 32'd1);
        reset = 1'b1;
        #1;
        check("reset_we_async", {31'd0, mem_write_enable}, 32'd0);
        @(negedge clk);
        check("reset_word5_unchanged", mem[5], old_word);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("post_reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("post_reset_mem_address", mem_address, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage between execute and the 256-word synchronous data memory.
- Accepts one load/store request at a time over a valid/ready handshake.
- Converts byte addresses to word addresses and performs sub-word stores as read-modify-write.
- Returns sign/zero-extended load data or an error flag over a valid/ready response channel.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the attached memory. Valid byte range is 0 to 4*MEM_WORDS-1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept (high only in IDLE)
- req_write  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved
- req_signed  in  1  loads: 1=sign-extend, 0=zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  load result (0 for stores and errors)
- resp_error  out  1  misaligned, out-of-range or reserved size
- mem_write_enable  out  1  to memory write enable
- mem_address  out  32  word address = latched req_addr >> 2
- mem_write_data  out  32  full word to write
- mem_read_data  in  32  memory registered read data; valid the cycle after the edge that sampled mem_address

Behaviour:
- Accept: request is accepted on a rising edge with req_valid && req_ready. Latch write, size, signed, addr and wdata.
- States: IDLE, ACCESS, MERGE, CAPTURE, RESP.
- Error check at accept. Error if any of:
  - size==3
  - half with addr[0]!=0
  - word with addr[1:0]!=0
  - addr >= 4*MEM_WORDS
- IDLE transitions:
  - error → RESP with resp_error=1, resp_rdata=0. No memory access.
  - word store → ACCESS, mem_write_enable=1, mem_write_data=wdata.
  - load or sub-word store → ACCESS, mem_write_enable=0.
- ACCESS (one cycle, mem_address driven):
  - word store → RESP; the write happens at the exiting edge.
  - load → CAPTURE.
  - sub-word store → MERGE.
- MERGE (one cycle): mem_write_enable=1. mem_write_data is mem_read_data with the addressed lane replaced:
  - byte: lane addr[1:0], bits 8*lane+7:8*lane ← wdata[7:0]
  - half: lane addr[1], bits 16*lane+15:16*lane ← wdata[15:0]
  - Then → RESP.
- CAPTURE (one cycle): register the extracted lane of mem_read_data, sign/zero-extended per latched req_signed, into resp_rdata. Then → RESP.
- RESP: resp_valid=1. resp_rdata and resp_error are stable until resp_valid && resp_ready, then → IDLE. No new request is accepted in the same cycle as the response handshake.
- Latency (accept edge to first resp_valid cycle):
  - error: 1 edge
  - word store: 2 edges
  - load: 3 edges
  - sub-word store: 3 edges
- mem_write_enable is high only in ACCESS (word store) or MERGE. It is decoded from state, so it is never high in IDLE, CAPTURE or RESP.
- mem_address: the latched word address in all states except IDLE, where it is 0.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_write_enable=0, mem_address=0, mem_write_data=0.
- Reset mid-operation: state returns to IDLE immediately and mem_write_enable drops asynchronously. If reset is asserted before the MERGE or ACCESS write edge, the memory word is left unmodified. A pending response is discarded.
- Requests arriving while busy are not accepted. The producer holds req_* stable until accepted.

Decomposition:
- Shared header mem_stage_defs: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state encodings, default MEM_WORDS.
- One combinational sub-module, lsu_lane_align, contains both:
  - store merge (old word, wdata, size, addr[1:0] → new word)
  - load extract (word, size, addr[1:0], signed → 32-bit result)
- The FSM instantiates lsu_lane_align once.

Test Plan:
- Word store 0xDEADBEEF @0x14, then word load @0x14 → store resp_valid 2 edges after accept; load returns 0xDEADBEEF 3 edges after accept; resp_error=0.
- Byte store 0xAA @0x15 over 0xDEADBEEF → memory word 5 = 0xDEADAAEF with exactly one write pulse. Byte load @0x15 returns 0xFFFFFFAA signed, 0x000000AA unsigned.
- Half loads @0x16 → 0xFFFFDEAD signed, 0x0000DEAD unsigned. Half store 0x1234 @0x14 → word 0xDEAD1234.
- Errors: half @0x15, word @0x402, word @0x400, size=3 → each gives resp_error=1, resp_rdata=0, resp_valid 1 edge after accept, and mem_write_enable never asserted.
- Backpressure: resp_ready held low 5 cycles after a load → resp_valid and resp_rdata held constant and req_ready=0. A queued req_valid is accepted only in the cycle after the handshake.
- Reset asserted during MERGE of half store @0x14 → mem_write_enable=0 the same cycle, word 5 unchanged, req_ready=1, resp_valid=0 after reset release.
